// File: rtl/ifetch_bridge.sv
// ifetch_bridge: connects the PC stage to a request/ack instruction bus.
// A single FSM (IDLE, REQ, WAIT, DONE, DROP) keeps at most one fetch
// outstanding. It holds the pipeline in stall while a fetch is in flight.
// It returns the fetched word, or an address-error flag, through
// registered outputs.
// Optional feature: define IFETCH_KSEG_MAP_EN to fold kseg0/kseg1 virtual
// addresses (addr[31:30] = 2'b10) onto physical space on the bus side.
module ifetch_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        ce,
  input  logic        flush,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] inst,
  output logic        inst_adel,
  output logic        stallreq
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DONE = 3'd3,
    DROP = 3'd4
  } state_t;

  state_t      state;
  // Fetch address, held from REQ entry until the transaction retires.
  logic [31:0] addr_r;

  // Fetch FSM: one transition per cycle; owns the address register and the
  // registered instruction / address-error outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_r    <= '0;
      inst      <= '0;
      inst_adel <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ce && !flush) begin
            if (pc[1:0] == 2'b00) begin
              addr_r <= pc;
              state  <= REQ;
            end else begin
              // Misaligned fetch never reaches the bus; report it directly.
              inst      <= '0;
              inst_adel <= 1'b1;
              state     <= DONE;
            end
          end
        end
        REQ: begin
          if (flush) begin
            // Once the bus has the address, its data must still be drained.
            state <= inst_addr_ok ? DROP : IDLE;
          end else if (inst_addr_ok) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (flush) begin
            state <= inst_data_ok ? IDLE : DROP;
          end else if (inst_data_ok) begin
            inst      <= inst_rdata;
            inst_adel <= 1'b0;
            state     <= DONE;
          end
        end
        DROP: begin
          // Absorb the data beat of the aborted fetch; flush is irrelevant.
          if (inst_data_ok) begin
            state <= IDLE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Bus request is a decode of the REQ state, suppressed during reset.
  assign inst_req = !rst && (state == REQ);

`ifdef IFETCH_KSEG_MAP_EN
  // kseg0/kseg1 fold onto the low 512 MB; everything else passes through.
  assign inst_addr = (addr_r[31:30] == 2'b10) ? {3'b000, addr_r[28:0]} : addr_r;
`else
  assign inst_addr = addr_r;
`endif

  // Stall while a fetch is pending or about to start; DONE releases it.
  always_comb begin
    stallreq = 1'b0;
    if (!rst) begin
      case (state)
        REQ, WAIT, DROP: stallreq = 1'b1;
        IDLE:            stallreq = ce && !flush;
        default:         stallreq = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_bridge.sv
// Testbench for ifetch_bridge: table of fetch transactions against a
// delay-programmable bus model with a scoreboard, followed by hand-written
// sequences for flush, drop and reset corner cases.
module tb_ifetch_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        ce;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [31:0] inst;
  logic        inst_adel;
  logic        stallreq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rdata;
    int          ad;        // extra REQ cycles before addr_ok
    int          dd;        // cycles from address accept to data_ok
    logic [31:0] exp_inst;
    logic        exp_adel;
    logic [31:0] addr_on;   // expected bus address with kseg mapping
    logic [31:0] addr_off;  // expected bus address without mapping
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic        adel;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[8];
  logic [31:0] last_inst;
  logic        last_adel;

  ifetch_bridge dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .ce           (ce),
    .flush        (flush),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .inst         (inst),
    .inst_adel    (inst_adel),
    .stallreq     (stallreq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drives one fetch: ce held until DONE is seen (stallreq drops while ce=1).
  task automatic do_fetch(input vec_t v);
    exp_t        e;
    exp_t        got;
    int          req_cnt = 0;
    int          wait_cnt = 0;
    int          exp_done;
    int          exp_reqs;
    bit          accepted = 1'b0;
    bit          done = 1'b0;
    logic [31:0] exp_addr;
`ifdef IFETCH_KSEG_MAP_EN
    exp_addr = v.addr_on;
`else
    exp_addr = v.addr_off;
`endif
    exp_done = (v.pc[1:0] == 2'b00) ? v.ad + 2 + v.dd : 1;
    exp_reqs = (v.pc[1:0] == 2'b00) ? v.ad + 1 : 0;
    e.inst = v.exp_inst;
    e.adel = v.exp_adel;
    sb.push_back(e);
    for (int it = 0; it < 64 && !done; it++) begin
      @(negedge clk);
      ce = 1'b1; pc = v.pc; flush = 1'b0;
      inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0BAD_0BAD;
      if (!accepted) begin
        if (inst_req) begin
          req_cnt++;
          chk("req_addr", inst_addr, exp_addr);
          if (req_cnt > v.ad) begin
            inst_addr_ok = 1'b1;
            accepted = 1'b1;
          end
        end
      end else begin
        chk("no_req_after_accept", 32'(inst_req), 32'd0);
        chk("addr_stable", inst_addr, exp_addr);
        wait_cnt++;
        if (wait_cnt == v.dd) begin
          inst_data_ok = 1'b1;
          inst_rdata = v.rdata;
        end
      end
      #1;
      if (!stallreq) begin
        done = 1'b1;
        chk("done_cycle", it, exp_done);
        chk("done_req", 32'(inst_req), 32'd0);
        chk("req_cycles", req_cnt, exp_reqs);
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard_empty pc=%h", v.pc);
        end else begin
          got = sb.pop_front();
          chk("inst", inst, got.inst);
          chk("inst_adel", 32'(inst_adel), 32'(got.adel));
          last_inst = got.inst;
          last_adel = got.adel;
        end
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL fetch_timeout pc=%h", v.pc);
      if (sb.size() != 0) void'(sb.pop_front());
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; flush = 1'b0; pc = '0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
    last_inst = '0; last_adel = 1'b0;

    //           pc            rdata         ad dd exp_inst      adel  addr_on       addr_off
    vecs[0] = '{32'hBFC0_0000, 32'h3C1A_8000, 0, 1, 32'h3C1A_8000, 1'b0, 32'h1FC0_0000, 32'hBFC0_0000};
    vecs[1] = '{32'h8000_0004, 32'h2442_0001, 2, 2, 32'h2442_0001, 1'b0, 32'h0000_0004, 32'h8000_0004};
    vecs[2] = '{32'hBFC0_0002, 32'hA5A5_A5A5, 0, 1, 32'h0000_0000, 1'b1, 32'hBFC0_0002, 32'hBFC0_0002};
    vecs[3] = '{32'h0040_0010, 32'h8C43_0000, 1, 3, 32'h8C43_0000, 1'b0, 32'h0040_0010, 32'h0040_0010};
    vecs[4] = '{32'hA000_0008, 32'h1234_ABCD, 0, 1, 32'h1234_ABCD, 1'b0, 32'h0000_0008, 32'hA000_0008};
    vecs[5] = '{32'hC000_0000, 32'hFFFF_FFFF, 0, 2, 32'hFFFF_FFFF, 1'b0, 32'hC000_0000, 32'hC000_0000};
    vecs[6] = '{32'h0000_0001, 32'h7777_7777, 0, 1, 32'h0000_0000, 1'b1, 32'h0000_0001, 32'h0000_0001};
    vecs[7] = '{32'h7FFF_FFFC, 32'h0F0F_0F0F, 3, 1, 32'h0F0F_0F0F, 1'b0, 32'h7FFF_FFFC, 32'h7FFF_FFFC};

    // Reset holds request and stall low even with ce asserted.
    @(negedge clk); ce = 1'b1; pc = 32'h0000_0040;
    #1 chk("rst_req", 32'(inst_req), 32'd0); chk("rst_stall", 32'(stallreq), 32'd0);
    @(negedge clk);
    #1 chk("rst_req2", 32'(inst_req), 32'd0); chk("rst_stall2", 32'(stallreq), 32'd0);
    @(negedge clk); rst = 1'b0; ce = 1'b0;
    #1 chk("rst_inst", inst, 32'd0); chk("rst_adel", 32'(inst_adel), 32'd0);
    chk("rst_addr", inst_addr, 32'd0); chk("rst_idle_req", 32'(inst_req), 32'd0);
    chk("rst_idle_stall", 32'(stallreq), 32'd0);

    for (int i = 0; i < 8; i++) do_fetch(vecs[i]);

    // Flush in WAIT, late data discarded in DROP; then withdraw in REQ.
    @(negedge clk); ce = 1'b1; pc = 32'h8000_1000; flush = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
    #1 chk("a_idle_stall", 32'(stallreq), 32'd1);
    @(negedge clk); ce = 1'b0; inst_addr_ok = 1'b1;
    #1 chk("a_req", 32'(inst_req), 32'd1);
    @(negedge clk); inst_addr_ok = 1'b0; flush = 1'b1;
    #1 chk("a_wait_req", 32'(inst_req), 32'd0); chk("a_wait_stall", 32'(stallreq), 32'd1);
    @(negedge clk); flush = 1'b0;
    #1 chk("a_drop_req", 32'(inst_req), 32'd0); chk("a_drop_stall", 32'(stallreq), 32'd1);
    @(negedge clk); inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF;
    #1 chk("a_drop_stall2", 32'(stallreq), 32'd1);
    @(negedge clk); inst_data_ok = 1'b0; ce = 1'b1; pc = 32'h0040_0000;
    #1 chk("a_no_done_stall", 32'(stallreq), 32'd1);
    chk("a_inst_kept", inst, last_inst); chk("a_adel_kept", 32'(inst_adel), 32'(last_adel));
    @(negedge clk); ce = 1'b0; flush = 1'b1; inst_addr_ok = 1'b0;
    #1 chk("a_withdraw_req", 32'(inst_req), 32'd1); chk("a_withdraw_addr", inst_addr, 32'h0040_0000);
    @(negedge clk); flush = 1'b0;
    #1 chk("a_withdrawn_req", 32'(inst_req), 32'd0); chk("a_withdrawn_stall", 32'(stallreq), 32'd0);

    // Flush with addr_ok -> DROP; flush with data_ok in WAIT -> IDLE.
    @(negedge clk); ce = 1'b1; pc = 32'h9FC0_0010;
    #1 chk("b_idle_stall", 32'(stallreq), 32'd1);
    @(negedge clk); ce = 1'b0; inst_addr_ok = 1'b1; flush = 1'b1;
    #1 chk("b_req", 32'(inst_req), 32'd1);
    @(negedge clk); inst_addr_ok = 1'b0; flush = 1'b1;
    #1 chk("b_drop_req", 32'(inst_req), 32'd0); chk("b_drop_stall", 32'(stallreq), 32'd1);
    @(negedge clk); flush = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h1234_5678;
    #1 chk("b_drop_stall2", 32'(stallreq), 32'd1);
    @(negedge clk); inst_data_ok = 1'b0;
    #1 chk("b_idle_stall2", 32'(stallreq), 32'd0); chk("b_inst_kept", inst, last_inst);
    @(negedge clk); ce = 1'b1; pc = 32'h0000_0100;
    #1 chk("b_idle_stall3", 32'(stallreq), 32'd1);
    @(negedge clk); ce = 1'b0; inst_addr_ok = 1'b1;
    #1 chk("b_req2", 32'(inst_req), 32'd1); chk("b_addr2", inst_addr, 32'h0000_0100);
    @(negedge clk); inst_addr_ok = 1'b0; flush = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'hCAFE_F00D;
    #1 chk("b_wait_req", 32'(inst_req), 32'd0); chk("b_wait_stall", 32'(stallreq), 32'd1);
    @(negedge clk); flush = 1'b0; inst_data_ok = 1'b0;
    #1 chk("b_idle_stall4", 32'(stallreq), 32'd0); chk("b_inst_kept2", inst, last_inst);
    chk("b_idle_req", 32'(inst_req), 32'd0);
    @(negedge clk); inst_data_ok = 1'b1; inst_rdata = 32'h1111_1111;
    @(negedge clk); inst_data_ok = 1'b0;
    #1 chk("b_stray_inst", inst, last_inst); chk("b_stray_stall", 32'(stallreq), 32'd0);

    // Reset in WAIT aborts the fetch; the late data beat is ignored.
    @(negedge clk); ce = 1'b1; pc = 32'hBFC0_0100;
    @(negedge clk); ce = 1'b0; inst_addr_ok = 1'b1;
    #1 chk("c_req", 32'(inst_req), 32'd1);
    @(negedge clk); inst_addr_ok = 1'b0; rst = 1'b1;
    #1 chk("c_rst_req", 32'(inst_req), 32'd0); chk("c_rst_stall", 32'(stallreq), 32'd0);
    @(negedge clk); rst = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h55AA_55AA;
    #1 chk("c_inst_zero", inst, 32'd0); chk("c_adel_zero", 32'(inst_adel), 32'd0);
    chk("c_stall", 32'(stallreq), 32'd0); chk("c_addr_zero", inst_addr, 32'd0);
    @(negedge clk); inst_data_ok = 1'b0;
    #1 chk("c_late_inst", inst, 32'd0); chk("c_late_stall", 32'(stallreq), 32'd0);
    chk("c_late_req", 32'(inst_req), 32'd0);
    last_inst = '0; last_adel = 1'b0;

    // ce with flush in IDLE: no stall, no fetch started.
    @(negedge clk); ce = 1'b1; flush = 1'b1; pc = 32'h0000_0200;
    #1 chk("d_flush_stall", 32'(stallreq), 32'd0);
    @(negedge clk); ce = 1'b0; flush = 1'b0;
    #1 chk("d_no_req", 32'(inst_req), 32'd0); chk("d_no_stall", 32'(stallreq), 32'd0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ifetch_bridge.md
IFETCH_BRIDGE -- requirements
Module: ifetch_bridge

Interface
REQ-001 SHALL have port clk  input  1  pipeline clock; all state changes on rising edge.
REQ-002 SHALL have port rst  input  1  reset; synchronous, active-high (`RstEnable` = 1).
REQ-003 SHALL have port pc  input  32  fetch address from the PC stage.
REQ-004 SHALL have port ce  input  1  fetch enable from the PC stage; 1 = fetch pc.
REQ-005 SHALL have port flush  input  1  exception/eret flush; aborts current fetch.
REQ-006 SHALL have port inst_req  output  1  bus request; high only in state REQ.
REQ-007 SHALL have port inst_addr  output  32  bus address, driven from the internal address register.
REQ-008 SHALL have port inst_addr_ok  input  1  bus accepted the address this cycle.
REQ-009 SHALL have port inst_data_ok  input  1  bus returns read data this cycle.
REQ-010 SHALL have port inst_rdata  input  32  bus read data; valid with inst_data_ok.
REQ-011 SHALL have port inst  output  32  fetched instruction to IF/ID, registered.
REQ-012 SHALL have port inst_adel  output  1  address-error-on-fetch flag for the instruction in inst.
REQ-013 SHALL have port stallreq  output  1  request pipeline stall while a fetch is outstanding.

Function
REQ-014 SHALL implement FSM states IDLE, REQ, WAIT, DONE, DROP; only one transition per cycle.
REQ-015 IDLE, ce=1, flush=0, pc[1:0]=0: SHALL latch pc into the address register and go to REQ.
REQ-016 IDLE, ce=1, flush=0, pc[1:0]!=0: SHALL issue no bus request, set inst=0 and inst_adel=1, and go to DONE.
REQ-017 IDLE, ce=0 or flush=1: SHALL remain in IDLE with inst and inst_adel unchanged.
REQ-018 REQ: inst_req=1; inst_addr_ok=1 SHALL go to WAIT; flush=1 with inst_addr_ok=1 SHALL go to DROP; flush=1 with inst_addr_ok=0 SHALL withdraw the request and go to IDLE.
REQ-019 WAIT, inst_data_ok=1, flush=0: SHALL load inst<=inst_rdata, set inst_adel=0, and go to DONE.
REQ-020 WAIT, flush=1: SHALL go to IDLE if inst_data_ok=1 in the same cycle (data discarded), else to DROP.
REQ-021 DROP: SHALL go to IDLE on inst_data_ok=1 without updating inst; flush in DROP SHALL have no further effect.
REQ-022 DONE: SHALL hold inst and inst_adel for exactly one cycle and then go to IDLE.
REQ-023 stallreq SHALL be combinational: 1 in REQ, WAIT and DROP, and in IDLE when ce=1 and flush=0; 0 otherwise, including in DONE.
REQ-024 Zero-wait bus (addr_ok in first REQ cycle, data_ok next cycle): ce sampled at edge N SHALL give inst valid with stallreq=0 in the cycle after edge N+2.
REQ-025 At most one bus transaction SHALL be outstanding; inst_req SHALL never be asserted in WAIT or DROP.
REQ-026 inst_addr SHALL stay stable from entry to REQ until leaving WAIT/DROP.

Reset
REQ-027 rst=1 at a clock edge SHALL force state IDLE, inst=0, inst_adel=0, and address register=0, overriding all other inputs.
REQ-028 rst SHALL abort a fetch mid-transaction; a late inst_data_ok after reset SHALL be ignored in IDLE.
REQ-029 While rst=1, inst_req=0 and stallreq=0.

Configuration
REQ-030 With macro IFETCH_KSEG_MAP_EN defined: inst_addr = {3'b000, addr[28:0]} when addr[31:30]=2'b10 (kseg0/kseg1); other addresses SHALL pass unchanged.
REQ-031 Without IFETCH_KSEG_MAP_EN: inst_addr SHALL equal the address register unmodified.

Verification
REQ-032 Reset then ce=1, pc=0xBFC00000, zero-wait bus -> inst_req 1 cycle; inst_addr=0x1FC00000 (macro on) or 0xBFC00000 (macro off); inst=rdata after 3 edges; stallreq low in DONE.
REQ-033 Bus with 3-cycle addr_ok delay and 2-cycle data_ok delay -> inst_req held 3 cycles; stallreq high continuously until DONE; inst_addr stable throughout.
REQ-034 flush in WAIT, data_ok 2 cycles later with rdata=0xDEADBEEF -> DROP then IDLE; inst keeps its old value; no DONE cycle.
REQ-035 flush coincident with addr_ok in REQ -> DROP; next data_ok discarded; flush coincident with data_ok in WAIT -> IDLE, inst unchanged.
REQ-036 ce=1, pc=0xBFC00002 -> no inst_req; DONE with inst=0, inst_adel=1; stallreq low in DONE.
REQ-037 rst asserted in WAIT -> IDLE, inst=0, stallreq=0 next cycle; following data_ok ignored.
